acc_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 8-bit accumulator datapath.
//  - Fetches 9-bit instructions and decodes them.
//  - Drives the register-file controls wen/acc_control/ra1/ra2, the ALU select and the data-memory handshake.
//  - Owns PC strobes and the EQ flag. Sits between instruction ROM, PC register, register file, ALU and data memory.

---
 rtl/acc_seq_pkg.sv | 88 ++++++++
 rtl/acc_seq_decode.sv | 87 ++++++++
 rtl/acc_sequencer.sv | 120 ++++++++++++
 tb/tb_acc_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_seq_pkg.sv
// Shared types and constants for the accumulator sequencer.
// The optional memory timeout (ACC_SEQ_TIMEOUT_EN) uses MEM_TIMEOUT and CNT_W.
package acc_seq_pkg;

    localparam int unsigned INSTR_W     = 9;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned REG_W       = 3;
    localparam int unsigned IMM_W       = 5;
    localparam int unsigned ACC_CTL_W   = 3;
    localparam int unsigned ALU_SEL_W   = 3;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLL  = 4'd4,
        OP_ADDI = 4'd5,
        OP_MOV  = 4'd6,
        OP_LDA  = 4'd7,
        OP_EQ   = 4'd8,
        OP_BRC  = 4'd9,
        OP_JR   = 4'd10,
        OP_JUMP = 4'd11,
        OP_LWR  = 4'd12,
        OP_STR  = 4'd13,
        OP_NOP  = 4'd14,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLL = 3'd4
    } alu_sel_e;

    // acc_control: bit 2 selects rf[ra2] as write target, bits 1:0 pick read operands
    localparam logic [ACC_CTL_W-1:0] RD_RR = 3'b000;
    localparam logic [ACC_CTL_W-1:0] RD_RA = 3'b001;
    localparam logic [ACC_CTL_W-1:0] RD_AR = 3'b010;
    localparam logic [ACC_CTL_W-1:0] RD_AA = 3'b011;
    localparam logic [ACC_CTL_W-1:0] WR_RF = 3'b100;

    typedef struct packed {
        logic                 wen;
        logic [ACC_CTL_W-1:0] acc_control;
        logic [REG_W-1:0]     ra1;
        logic [REG_W-1:0]     ra2;
        alu_sel_e             alu_sel;
        logic [IMM_W-1:0]     imm;
        logic                 imm_sel;
        logic                 fetch_en;
        logic                 pc_inc;
        logic                 pc_load;
        logic                 mem_req;
        logic                 mem_we;
        logic                 busy;
        logic                 done;
        logic                 err;
    } ctrl_t;

    // ALU function for an opcode; everything without its own function adds
    function automatic alu_sel_e alu_for(opcode_e op);
        alu_sel_e sel;
        case (op)
            OP_SUB, OP_EQ: sel = ALU_SUB;
            OP_AND:        sel = ALU_AND;
            OP_OR:         sel = ALU_OR;
            OP_SLL:        sel = ALU_SLL;
            default:       sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/acc_seq_decode.sv
// Control decode: state + IR + EQ flag -> datapath/PC/memory controls.
// The ERR indication only exists when ACC_SEQ_TIMEOUT_EN is defined.
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  state_e               state_i,
    input  logic [INSTR_W-1:0]   ir_i,
    input  logic                 flag_i,
    input  logic                 mem_ack_i,
    output ctrl_t                ctrl_o
);

    opcode_e op;

    // Controls follow the registered state/IR; only the MEM ack-cycle strobes track mem_ack
    always_comb begin
        op             = opcode_e'(ir_i[INSTR_W-1 -: OP_W]);
        ctrl_o         = '0;
        ctrl_o.ra1     = ir_i[REG_W-1:0];
        ctrl_o.ra2     = ir_i[REG_W-1:0];
        ctrl_o.imm     = ir_i[IMM_W-1:0];
        case (state_i)
            S_FETCH: begin
                ctrl_o.fetch_en = 1'b1;
                ctrl_o.busy     = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.busy = 1'b1;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_ADDI: begin
                        ctrl_o.acc_control = RD_AR;
                        ctrl_o.wen         = 1'b1;
                        ctrl_o.pc_inc      = 1'b1;
                        ctrl_o.alu_sel     = alu_for(op);
                        ctrl_o.imm_sel     = (op == OP_ADDI);
                    end
                    OP_MOV: begin
                        ctrl_o.acc_control = WR_RF | RD_RA;
                        ctrl_o.wen         = 1'b1;
                        ctrl_o.pc_inc      = 1'b1;
                    end
                    OP_LDA: begin
                        ctrl_o.acc_control = RD_RR;
                        ctrl_o.wen         = 1'b1;
                        ctrl_o.pc_inc      = 1'b1;
                    end
                    OP_EQ: begin
                        ctrl_o.acc_control = RD_AR;
                        ctrl_o.alu_sel     = alu_for(op);
                        ctrl_o.pc_inc      = 1'b1;
                    end
                    OP_BRC: begin
                        ctrl_o.pc_load = flag_i;
                        ctrl_o.pc_inc  = ~flag_i;
                    end
                    OP_JR: begin
                        ctrl_o.acc_control = RD_RA;
                        ctrl_o.pc_load     = 1'b1;
                    end
                    OP_JUMP: begin
                        ctrl_o.acc_control = RD_AA;
                        ctrl_o.pc_load     = 1'b1;
                    end
                    OP_LWR, OP_STR: ctrl_o.acc_control = RD_RA;
                    OP_NOP:         ctrl_o.pc_inc      = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                ctrl_o.busy        = 1'b1;
                ctrl_o.acc_control = RD_RA;
                ctrl_o.mem_req     = 1'b1;
                ctrl_o.mem_we      = (op == OP_STR);
                if (mem_ack_i) begin
                    ctrl_o.pc_inc = 1'b1;
                    ctrl_o.wen    = (op == OP_LWR);
                end
            end
            S_DONE: ctrl_o.done = 1'b1;
`ifdef ACC_SEQ_TIMEOUT_EN
            S_ERR:  ctrl_o.err  = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// Multi-cycle control FSM for the 8-bit accumulator datapath.
// Holds state, IR and EQ flag; control outputs are decoded from them.
// Optional ACC_SEQ_TIMEOUT_EN: MEM gives up after MEM_TIMEOUT cycles -> sticky ERR.
module acc_sequencer
    import acc_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 alu_zero,
    input  logic                 mem_ack,
    output logic                 wen,
    output logic [ACC_CTL_W-1:0] acc_control,
    output logic [REG_W-1:0]     ra1,
    output logic [REG_W-1:0]     ra2,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic [IMM_W-1:0]     imm,
    output logic                 imm_sel,
    output logic                 fetch_en,
    output logic                 pc_inc,
    output logic                 pc_load,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_e               state_q;
    logic [INSTR_W-1:0]   ir_q;
    logic                 flag_q;
    opcode_e              op;
    ctrl_t                ctrl;

    assign op = opcode_e'(ir_q[INSTR_W-1 -: OP_W]);

`ifdef ACC_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] mem_wait_q;

    // MEM wait counter: zero on MEM entry, one step per MEM cycle
    always_ff @(posedge clk) begin
        if (reset || state_q != S_MEM) begin
            mem_wait_q <= '0;
        end else begin
            mem_wait_q <= mem_wait_q + 1'b1;
        end
    end
`endif

    // Sequencer state, instruction register and EQ flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            flag_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    ir_q    <= instr;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (op == OP_EQ) begin
                        flag_q <= alu_zero;
                    end else if (op == OP_BRC) begin
                        flag_q <= 1'b0;
                    end
                    if (op == OP_LWR || op == OP_STR) begin
                        state_q <= S_MEM;
                    end else if (op == OP_HALT) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        state_q <= S_FETCH;
                    end
`ifdef ACC_SEQ_TIMEOUT_EN
                    else if (mem_wait_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state_q <= S_ERR;
                    end
`endif
                end
                S_ERR: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    acc_seq_decode u_decode (
        .state_i   (state_q),
        .ir_i      (ir_q),
        .flag_i    (flag_q),
        .mem_ack_i (mem_ack),
        .ctrl_o    (ctrl)
    );

    assign wen         = ctrl.wen;
    assign acc_control = ctrl.acc_control;
    assign ra1         = ctrl.ra1;
    assign ra2         = ctrl.ra2;
    assign alu_sel     = ctrl.alu_sel;
    assign imm         = ctrl.imm;
    assign imm_sel     = ctrl.imm_sel;
    assign fetch_en    = ctrl.fetch_en;
    assign pc_inc      = ctrl.pc_inc;
    assign pc_load     = ctrl.pc_load;
    assign mem_req     = ctrl.mem_req;
    assign mem_we      = ctrl.mem_we;
    assign busy        = ctrl.busy;
    assign done        = ctrl.done;
    assign err         = ctrl.err;

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: a program-level model plans per-cycle
// stimulus and expected controls; a monitor compares every cycle.
module tb_acc_sequencer;
    import acc_seq_pkg::*;

    typedef struct packed {
        logic       wen;
        logic [2:0] acc_control;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [2:0] alu_sel;
        logic [4:0] imm;
        logic       imm_sel;
        logic       fetch_en;
        logic       pc_inc;
        logic       pc_load;
        logic       mem_req;
        logic       mem_we;
        logic       busy;
        logic       done;
        logic       err;
    } obs_t;

    typedef struct packed {
        logic       reset;
        logic       start;
        logic [8:0] instr;
        logic       alu_zero;
        logic       mem_ack;
    } stim_t;

`ifdef ACC_SEQ_TIMEOUT_EN
    localparam int MAXW = 14;
`else
    localparam int MAXW = 20;
`endif

    logic       clk = 1'b0;
    logic       reset, start, alu_zero, mem_ack;
    logic [8:0] instr;
    logic       wen, imm_sel, fetch_en, pc_inc, pc_load, mem_req, mem_we, busy, done, err;
    logic [2:0] acc_control, ra1, ra2, alu_sel;
    logic [4:0] imm;

    always #5 clk = ~clk;

    acc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .alu_zero(alu_zero), .mem_ack(mem_ack),
        .wen(wen), .acc_control(acc_control), .ra1(ra1), .ra2(ra2),
        .alu_sel(alu_sel), .imm(imm), .imm_sel(imm_sel), .fetch_en(fetch_en),
        .pc_inc(pc_inc), .pc_load(pc_load), .mem_req(mem_req), .mem_we(mem_we),
        .busy(busy), .done(done), .err(err)
    );

    // planned cycles and the live scoreboard
    stim_t plan_s[$];
    obs_t  plan_e[$];
    string plan_t[$];
    obs_t  exp_q[$];
    string tag_q[$];

    // program-level model: current instruction word, EQ flag, halted
    logic [8:0] ir_m;
    logic       flag_m;
    bit         halted;
    bit         force_start;

    int n_vec = 0;
    int n_bad = 0;

    function automatic void push(stim_t s, obs_t e, string t);
        plan_s.push_back(s);
        plan_e.push_back(e);
        plan_t.push_back(t);
    endfunction

    // don't-care inputs get random values; start is forced high when asked
    function automatic stim_t noise();
        stim_t s;
        s.reset    = 1'b0;
        s.start    = force_start | 1'($urandom);
        s.instr    = 9'($urandom);
        s.alu_zero = 1'($urandom);
        s.mem_ack  = 1'($urandom);
        return s;
    endfunction

    // nothing active: register addresses and immediate come from the held instruction
    function automatic obs_t quiet();
        obs_t e = '0;
        e.ra1 = ir_m[2:0];
        e.ra2 = ir_m[2:0];
        e.imm = ir_m[4:0];
        return e;
    endfunction

    function automatic obs_t exec_exp(opcode_e op);
        obs_t e = quiet();
        e.busy = 1'b1;
        case (op)
            OP_ADD:  begin e.acc_control = 3'b010; e.wen = 1; e.pc_inc = 1; e.alu_sel = ALU_ADD; end
            OP_SUB:  begin e.acc_control = 3'b010; e.wen = 1; e.pc_inc = 1; e.alu_sel = ALU_SUB; end
            OP_AND:  begin e.acc_control = 3'b010; e.wen = 1; e.pc_inc = 1; e.alu_sel = ALU_AND; end
            OP_OR:   begin e.acc_control = 3'b010; e.wen = 1; e.pc_inc = 1; e.alu_sel = ALU_OR;  end
            OP_SLL:  begin e.acc_control = 3'b010; e.wen = 1; e.pc_inc = 1; e.alu_sel = ALU_SLL; end
            OP_ADDI: begin e.acc_control = 3'b010; e.wen = 1; e.pc_inc = 1; e.imm_sel = 1; end
            OP_MOV:  begin e.acc_control = 3'b101; e.wen = 1; e.pc_inc = 1; end
            OP_LDA:  begin e.acc_control = 3'b000; e.wen = 1; e.pc_inc = 1; end
            OP_EQ:   begin e.acc_control = 3'b010; e.pc_inc = 1; e.alu_sel = ALU_SUB; end
            OP_BRC:  begin e.pc_load = flag_m; e.pc_inc = !flag_m; end
            OP_JR:   begin e.acc_control = 3'b001; e.pc_load = 1; end
            OP_JUMP: begin e.acc_control = 3'b011; e.pc_load = 1; end
            OP_LWR, OP_STR: e.acc_control = 3'b001;
            OP_NOP:  e.pc_inc = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t mem_exp(opcode_e op, logic ack);
        obs_t e = quiet();
        e.busy        = 1'b1;
        e.acc_control = 3'b001;
        e.mem_req     = 1'b1;
        e.mem_we      = (op == OP_STR);
        e.pc_inc      = ack;
        e.wen         = ack && (op == OP_LWR);
        return e;
    endfunction

    // IDLE/DONE cycles without a start pulse
    function automatic void park(int n);
        for (int k = 0; k < n; k++) begin
            stim_t s = noise();
            obs_t  e = quiet();
            s.start = 1'b0;
            e.done  = halted;
            push(s, e, halted ? "done_hold" : "idle_hold");
        end
    endfunction

    function automatic void kick();
        stim_t s = noise();
        obs_t  e = quiet();
        s.start = 1'b1;
        e.done  = halted;
        push(s, e, "start");
        halted = 1'b0;
    endfunction

    // one instruction: fetch, execute, then memory wait/ack cycles if it touches memory
    function automatic void run(opcode_e op, logic [4:0] low, logic az, int waits, bit ack);
        stim_t s;
        obs_t  e;
        s = noise();
        s.instr = {op, low};
        e = quiet();
        e.fetch_en = 1'b1;
        e.busy     = 1'b1;
        push(s, e, $sformatf("%s/fetch", op.name()));
        ir_m = {op, low};

        s = noise();
        s.alu_zero = az;
        push(s, exec_exp(op), $sformatf("%s/exec", op.name()));
        if (op == OP_EQ)  flag_m = az;
        if (op == OP_BRC) flag_m = 1'b0;
        if (op == OP_HALT) halted = 1'b1;

        if (op == OP_LWR || op == OP_STR) begin
            for (int w = 0; w < waits; w++) begin
                s = noise();
                s.mem_ack = 1'b0;
                push(s, mem_exp(op, 1'b0), $sformatf("%s/wait%0d", op.name(), w));
            end
            if (ack) begin
                s = noise();
                s.mem_ack = 1'b1;
                push(s, mem_exp(op, 1'b1), $sformatf("%s/ack", op.name()));
            end
        end
    endfunction

    // reset cycle: outputs still show the pre-reset state, model returns to IDLE
    function automatic void reset_pulse(obs_t e, bit with_start, string t);
        stim_t s = noise();
        s.reset   = 1'b1;
        s.start   = with_start;
        s.mem_ack = 1'b0;
        push(s, e, t);
        ir_m   = '0;
        flag_m = 1'b0;
        halted = 1'b0;
    endfunction

    function automatic void build();
        obs_t e;
        park(2);
        kick();
        run(OP_ADD, 5'd3, 1'($urandom), 0, 1);
        run(OP_MOV, 5'd5, 1'($urandom), 0, 1);
        run(OP_EQ,  5'd1, 1'b1, 0, 1);
        run(OP_BRC, 5'd0, 1'($urandom), 0, 1);
        run(OP_EQ,  5'd2, 1'b0, 0, 1);
        run(OP_BRC, 5'd7, 1'($urandom), 0, 1);
        run(OP_LWR, 5'd4, 1'($urandom), 3, 1);
        run(OP_ADDI, 5'h1f, 1'($urandom), 0, 1);
        run(OP_JR,   5'd2, 1'($urandom), 0, 1);
        run(OP_JUMP, 5'd6, 1'($urandom), 0, 1);
        run(OP_LDA,  5'd1, 1'($urandom), 0, 1);
        run(OP_STR,  5'd3, 1'($urandom), 0, 1);
        run(OP_HALT, 5'd0, 1'($urandom), 0, 1);
        park(2);
        kick();
        force_start = 1'b1;
        run(OP_SUB, 5'd4, 1'($urandom), 0, 1);
        run(OP_LWR, 5'd2, 1'($urandom), 2, 1);
        force_start = 1'b0;
        run(OP_STR, 5'd6, 1'($urandom), 5, 0);
        reset_pulse(mem_exp(OP_STR, 1'b0), 1'b0, "reset_in_mem");
        park(2);
        e = quiet();
        reset_pulse(e, 1'b1, "reset_and_start");
        park(1);
`ifdef ACC_SEQ_TIMEOUT_EN
        kick();
        run(OP_STR, 5'd7, 1'($urandom), MEM_TIMEOUT, 0);
        for (int k = 0; k < 3; k++) begin
            stim_t s = noise();
            e = quiet();
            e.err = 1'b1;
            push(s, e, "err_sticky");
        end
        e = quiet();
        e.err = 1'b1;
        reset_pulse(e, 1'b0, "reset_from_err");
        park(1);
`endif
        kick();
        for (int n = 0; n < 300; n++) begin
            opcode_e op = opcode_e'(4'($urandom_range(0, 15)));
            run(op, 5'($urandom), 1'($urandom), int'($urandom_range(0, MAXW)), 1);
            if (op == OP_HALT) begin
                park(int'($urandom_range(0, 2)));
                kick();
            end
        end
        run(OP_HALT, 5'd0, 1'b0, 0, 1);
        park(2);
    endfunction

    // monitor: compare DUT controls against the scoreboard head each cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                obs_t  want;
                obs_t  got;
                string t;
                want = exp_q.pop_front();
                t    = tag_q.pop_front();
                got  = {wen, acc_control, ra1, ra2, alu_sel, imm, imm_sel, fetch_en,
                        pc_inc, pc_load, mem_req, mem_we, busy, done, err};
                n_vec++;
                if (got !== want) begin
                    n_bad++;
                    $display("FAIL %s @%0t: got %h want %h (diff %h)", t, $time, got, want, got ^ want);
                end
                if (t == "err_sticky" &&
                    (err !== 1'b1 || wen !== 1'b0 || pc_inc !== 1'b0 || pc_load !== 1'b0 ||
                     mem_req !== 1'b0 || mem_we !== 1'b0 || fetch_en !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL expired_wait @%0t: err=%b wen=%b pc_inc=%b pc_load=%b mem_req=%b mem_we=%b fetch_en=%b",
                             $time, err, wen, pc_inc, pc_load, mem_req, mem_we, fetch_en);
                end
            end
        end
    end

    // driver: apply each planned cycle just after the edge and post its expectation
    initial begin
        obs_t rst_got;
        reset       = 1'b1;
        start       = 1'b0;
        instr       = '0;
        alu_zero    = 1'b0;
        mem_ack     = 1'b0;
        ir_m        = '0;
        flag_m      = 1'b0;
        halted      = 1'b0;
        force_start = 1'b0;
        build();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_got = {wen, acc_control, ra1, ra2, alu_sel, imm, imm_sel, fetch_en,
                   pc_inc, pc_load, mem_req, mem_we, busy, done, err};
        n_vec++;
        if (rst_got !== '0) begin
            n_bad++;
            $display("FAIL reset_state @%0t: got %h want %h", $time, rst_got, obs_t'('0));
        end
        foreach (plan_s[k]) begin
            @(posedge clk);
            #1;
            {reset, start, instr, alu_zero, mem_ack} = plan_s[k];
            exp_q.push_back(plan_e[k]);
            tag_q.push_back(plan_t[k]);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0 || n_vec == 0) begin
            $display("FAIL: %0d miscompares over %0d vectors", n_bad, n_vec);
        end else begin
            $display("PASS");
        end
        $finish;
    end

endmodule
